// File: rtl/fetch_bundle_splitter.sv
// -----------------------------------------------------------------------------
// fetch_bundle_splitter
//   Takes two-instruction fetch bundles from the head of a fetch FIFO and
//   presents them to decode one instruction at a time, low word first.
//   A bundle whose PC has bit 2 set was entered mid-bundle (branch target),
//   so its low word is skipped and only the high word is issued.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_i          synchronous active-high reset
//   fifo_valid_i   fetch FIFO head bundle is valid
//   fifo_data_i    head bundle, low word in [WIDTH/2-1:0]
//   fifo_pc_i      PC of head bundle
//   fifo_pop_o     pop the head bundle this cycle (combinational)
//   flush_i        drop the held bundle (redirect), wins over everything
//   inst_valid_o   instruction presented to decode
//   inst_data_o    presented instruction
//   inst_pc_o      PC of presented instruction
//   inst_accept_i  decode takes the presented instruction this cycle
// -----------------------------------------------------------------------------
module fetch_bundle_splitter #(
   parameter int WIDTH    = 64,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                fifo_valid_i,
   input  logic [WIDTH-1:0]    fifo_data_i,
   input  logic [PC_WIDTH-1:0] fifo_pc_i,
   output logic                fifo_pop_o,
   input  logic                flush_i,
   output logic                inst_valid_o,
   output logic [WIDTH/2-1:0]  inst_data_o,
   output logic [PC_WIDTH-1:0] inst_pc_o,
   input  logic                inst_accept_i
);

   localparam int HW = WIDTH / 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LO    = 2'd1,
      HI    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     bundle_q;
   logic [PC_WIDTH-1:0]  pc_q;
   // Which half was presented last; kept while EMPTY so the outputs hold.
   logic                 hi_sel_q;
   logic                 pop;
   // Bits [2:0] of the stored PC are rebuilt from hi_sel_q, never read.
   logic                 pc_low_unused;

   assign pc_low_unused = ^pc_q[2:0];

   // A new bundle is taken when nothing is held, or when the high word
   // leaves this cycle -- the latter keeps issue bubble-free.
   assign pop = fifo_valid_i && !flush_i &&
                (state_q == EMPTY || (state_q == HI && inst_accept_i));

   // ---- state register ----
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   // ---- next state ----
   always_comb begin
      state_d = state_q;
      if (flush_i)
         state_d = EMPTY;
      else if (pop)
         state_d = fifo_pc_i[2] ? HI : LO;
      else begin
         case (state_q)
            LO:      if (inst_accept_i) state_d = HI;
            HI:      if (inst_accept_i) state_d = EMPTY;
            default: state_d = state_q;
         endcase
      end
   end

   // ---- bundle / PC / half-select registers ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bundle_q <= '0;
         pc_q     <= '0;
         hi_sel_q <= 1'b0;
      end else begin
         if (pop) begin
            bundle_q <= fifo_data_i;
            pc_q     <= fifo_pc_i;
         end
         if (state_d != EMPTY)
            hi_sel_q <= (state_d == HI);
      end
   end

   // ---- outputs ----
   always_comb begin
      fifo_pop_o   = pop;
      inst_valid_o = (state_q != EMPTY);
      inst_data_o  = hi_sel_q ? bundle_q[WIDTH-1:HW] : bundle_q[HW-1:0];
      inst_pc_o    = {pc_q[PC_WIDTH-1:3], hi_sel_q, 2'b00};
   end

endmodule

// File: tb/tb_fetch_bundle_splitter.sv
// Directed bench for fetch_bundle_splitter. Inputs change 1 time unit after
// the rising edge; outputs are compared 1 unit later, well before the next edge.
module tb_fetch_bundle_splitter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        fifo_valid_i;
   logic [63:0] fifo_data_i;
   logic [31:0] fifo_pc_i;
   logic        fifo_pop_o;
   logic        flush_i;
   logic        inst_valid_o;
   logic [31:0] inst_data_o;
   logic [31:0] inst_pc_o;
   logic        inst_accept_i;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fetch_bundle_splitter #(.WIDTH(64), .PC_WIDTH(32)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .fifo_valid_i  (fifo_valid_i),
      .fifo_data_i   (fifo_data_i),
      .fifo_pc_i     (fifo_pc_i),
      .fifo_pop_o    (fifo_pop_o),
      .flush_i       (flush_i),
      .inst_valid_o  (inst_valid_o),
      .inst_data_o   (inst_data_o),
      .inst_pc_o     (inst_pc_o),
      .inst_accept_i (inst_accept_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fifo(input logic v, input logic [63:0] d, input logic [31:0] pc);
      fifo_valid_i = v;
      fifo_data_i  = d;
      fifo_pc_i    = pc;
   endtask

   task automatic out(input string tag, input logic v, input logic [31:0] d,
                      input logic [31:0] pc, input logic pop);
      chk({tag, ".valid"}, inst_valid_o, v);
      chk({tag, ".data"},  inst_data_o,  d);
      chk({tag, ".pc"},    inst_pc_o,    pc);
      chk({tag, ".pop"},   fifo_pop_o,   pop);
   endtask

   initial begin
      logic [31:0] w;
      int          nb;

      rst_i = 1'b1; flush_i = 1'b0; inst_accept_i = 1'b0;
      fifo(1'b0, 64'h0, 32'h0);
      tick(); tick();
      rst_i = 1'b0;
      #1 out("reset", 1'b0, 32'h0, 32'h0, 1'b0);

      // ---- aligned bundle ----
      fifo(1'b1, 64'hBBBB0002_AAAA0001, 32'h1000); inst_accept_i = 1'b1;
      #1 out("al.pop", 1'b0, 32'h0, 32'h0, 1'b1);
      tick(); fifo(1'b0, 64'h0, 32'h0);
      #1 out("al.lo", 1'b1, 32'hAAAA0001, 32'h1000, 1'b0);
      tick();
      #1 out("al.hi", 1'b1, 32'hBBBB0002, 32'h1004, 1'b0);
      tick();
      #1 out("al.empty", 1'b0, 32'hBBBB0002, 32'h1004, 1'b0);

      // ---- mid-bundle entry, pop on accept of the high word ----
      fifo(1'b1, 64'h22220002_11110001, 32'h2004);
      #1 chk("mid.pop0", fifo_pop_o, 1'b1);
      tick(); fifo(1'b1, 64'h44440004_33330003, 32'h2008);
      #1 out("mid.hi", 1'b1, 32'h22220002, 32'h2004, 1'b1);
      tick(); fifo(1'b1, 64'h66660006_55550005, 32'h3000); inst_accept_i = 1'b0;
      #1 out("bp.lo", 1'b1, 32'h33330003, 32'h2008, 1'b0);

      // ---- back-pressure in LO ----
      for (int i = 0; i < 5; i++) begin
         tick();
         #1 out("bp.hold", 1'b1, 32'h33330003, 32'h2008, 1'b0);
      end
      inst_accept_i = 1'b1;
      tick(); fifo(1'b0, 64'h0, 32'h0);
      #1 out("bp.hi", 1'b1, 32'h44440004, 32'h200C, 1'b0);
      tick();
      #1 out("bp.empty", 1'b0, 32'h44440004, 32'h200C, 1'b0);

      // ---- streaming: 4 aligned bundles, accept held high ----
      fifo(1'b1, 64'hC0000001_C0000000, 32'h4000);
      #1 chk("st.pop0", fifo_pop_o, 1'b1);
      tick();
      nb = 1;
      for (int i = 0; i < 8; i++) begin
         if (nb < 4)
            fifo(1'b1, {32'hC0000001 + 32'(2*nb), 32'hC0000000 + 32'(2*nb)},
                 32'h4000 + 32'(8*nb));
         else
            fifo(1'b0, 64'h0, 32'h0);
         w = 32'hC0000000 + 32'(i);
         #1 out("st", 1'b1, w, 32'h4000 + 32'(4*i), ((i % 2) == 1) && (nb < 4));
         tick();
         if ((i % 2) == 1 && nb < 4) nb++;
      end
      fifo(1'b0, 64'h0, 32'h0);
      #1 chk("st.done", inst_valid_o, 1'b0);

      // ---- flush in HI with a valid head ----
      fifo(1'b1, 64'h88880008_77770007, 32'h5000);
      tick(); fifo(1'b0, 64'h0, 32'h0);
      tick();
      fifo(1'b1, 64'hAAAA000A_9999_0009, 32'h6000); flush_i = 1'b1;
      #1 out("fl.hi", 1'b1, 32'h88880008, 32'h5004, 1'b0);
      tick(); flush_i = 1'b0;
      #1 out("fl.empty", 1'b0, 32'h88880008, 32'h5004, 1'b1);
      tick();
      #1 out("fl.load", 1'b1, 32'h99990009, 32'h6000, 1'b0);
      tick();
      fifo(1'b1, 64'hCCCC000C_BBBB000B, 32'h7000);
      #1 out("fl.hi2", 1'b1, 32'hAAAA000A, 32'h6004, 1'b1);

      // ---- reset while in LO ----
      tick(); fifo(1'b0, 64'h0, 32'h0);
      #1 chk("rs.lo", inst_data_o, 32'hBBBB000B);
      rst_i = 1'b1;
      tick(); rst_i = 1'b0;
      #1 out("rs.after", 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      #1 out("rs.nohi", 1'b0, 32'h0, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_bundle_splitter.md
FETCH_BUNDLE_SPLITTER -- requirements
Module: fetch_bundle_splitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, fetch bundle width (two 32-bit instructions).
REQ-002 The block SHALL have parameter PC_WIDTH, default 32, program counter width.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port fifo_valid_i  input  1  fetch FIFO holds at least one bundle.
REQ-006 The block SHALL have port fifo_data_i  input  WIDTH  head bundle; [31:0] is the low word, [63:32] the high word.
REQ-007 The block SHALL have port fifo_pc_i  input  PC_WIDTH  PC of the head bundle.
REQ-008 The block SHALL have port fifo_pop_o  output  1  pop the head bundle this cycle.
REQ-009 The block SHALL have port flush_i  input  1  discard the held bundle (branch redirect).
REQ-010 The block SHALL have port inst_valid_o  output  1  an instruction is presented to decode.
REQ-011 The block SHALL have port inst_data_o  output  WIDTH/2  presented instruction.
REQ-012 The block SHALL have port inst_pc_o  output  PC_WIDTH  PC of the presented instruction.
REQ-013 The block SHALL have port inst_accept_i  input  1  decode takes the presented instruction this cycle.

Function
REQ-014 The block SHALL implement states EMPTY, LO and HI, held in a register, plus a WIDTH-bit bundle register and a PC_WIDTH-bit PC register.
REQ-015 fifo_pop_o SHALL be combinational: fifo_valid_i && !flush_i && (state==EMPTY || (state==HI && inst_accept_i)).
REQ-016 On a pop, the block SHALL capture fifo_data_i and fifo_pc_i and enter LO if fifo_pc_i[2]==0, else HI, so the low word of a mid-bundle entry is skipped.
REQ-017 In LO: inst_valid_o=1, inst_data_o=bundle[31:0], inst_pc_o={pc[PC_WIDTH-1:3],3'b000}; on inst_accept_i the block SHALL go to HI with no bubble.
REQ-018 In HI: inst_valid_o=1, inst_data_o=bundle[63:32], inst_pc_o={pc[PC_WIDTH-1:3],3'b100}; on inst_accept_i the block SHALL load the next bundle in the same cycle if fifo_valid_i, else go to EMPTY.
REQ-019 In EMPTY, inst_valid_o SHALL be 0, and inst_data_o and inst_pc_o SHALL hold their last values.
REQ-020 While inst_valid_o=1 and inst_accept_i=0, inst_data_o and inst_pc_o SHALL remain stable.
REQ-021 inst_accept_i SHALL be ignored when inst_valid_o=0.
REQ-022 Instruction order SHALL be preserved: each bundle issues low before high, and no bundle issues before all earlier bundles.
REQ-023 flush_i=1 SHALL force the next state to EMPTY, suppress fifo_pop_o in that cycle, and take priority over inst_accept_i and fifo_valid_i.
REQ-024 An accept coinciding with flush SHALL still count as consumed by decode; the block SHALL NOT re-present that instruction.
REQ-025 Throughput SHALL be one instruction per cycle while fifo_valid_i and inst_accept_i stay high.
REQ-026 Latency from pop to first inst_valid_o SHALL be 1 cycle.

Reset
REQ-027 While rst_i=1 at a clock edge, the block SHALL set state=EMPTY, and the bundle and PC registers to 0.
REQ-028 In the cycle after reset: inst_valid_o=0, inst_data_o=0, inst_pc_o=0, fifo_pop_o=0 unless fifo_valid_i=1.
REQ-029 Reset mid-operation SHALL drop any held bundle without issuing its remaining word.

Verification
REQ-030 Aligned bundle: push {0xBBBB0002,0xAAAA0001} at PC 0x1000, accept held high -> 0xAAAA0001@0x1000, then 0xBBBB0002@0x1004 on consecutive cycles, one fifo_pop_o pulse.
REQ-031 Mid-bundle entry: bundle at PC 0x2004 -> only the high word is issued @0x2004, and the pop occurs on the cycle that word is accepted if a second bundle is valid.
REQ-032 Back-pressure: inst_accept_i low for 5 cycles in LO -> outputs stable, fifo_pop_o=0 throughout; issue resumes on the next accept.
REQ-033 Streaming: 4 aligned bundles back-to-back with accept=1 -> 8 instructions in 8 consecutive cycles, PCs incrementing by 4.
REQ-034 Flush in HI with fifo_valid_i=1 -> no pop that cycle; next cycle inst_valid_o=0; the following cycle the new head is loaded.
REQ-035 rst_i asserted in LO -> next cycle inst_valid_o=0 and all outputs 0; the held high word is never issued.
